// File: rtl/mem_arb_pkg.sv
// Shared types for the data RAM arbiter: FSM state and current RAM owner.
package mem_arb_pkg;

    typedef enum logic {
        S_PIPE = 1'b0,
        S_LOAD = 1'b1
    } arb_state_e;

    typedef enum logic {
        OWN_PIPE = 1'b0,
        OWN_LOAD = 1'b1
    } arb_owner_e;

endpackage

// File: rtl/data_mem_arbiter.sv
// Shares the single-port data RAM between the pipeline memory stage and the loader port.
// Latency: pipeline 0 cycles; loader write commits at the grant edge, loader read data 1 cycle after grant.
// Backpressure: loader waits on ld_gnt_o (at most MAX_WAIT cycles); pipeline frozen by pipe_stall_o (at most BURST_MAX cycles).
module data_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int MAX_WAIT  = 4,
    parameter int BURST_MAX = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pipe_req_i,
    input  logic             pipe_we_i,
    input  logic [WIDTH-1:0] pipe_addr_i,
    input  logic [WIDTH-1:0] pipe_wdata_i,
    output logic [WIDTH-1:0] pipe_rdata_o,
    output logic             pipe_stall_o,
    input  logic             ld_req_i,
    input  logic             ld_we_i,
    input  logic [WIDTH-1:0] ld_addr_i,
    input  logic [WIDTH-1:0] ld_wdata_i,
    input  logic             ld_last_i,
    output logic             ld_gnt_o,
    output logic [WIDTH-1:0] ld_rdata_o,
    output logic             ld_rvalid_o,
    output logic [WIDTH-1:0] ram_adr_o,
    output logic [WIDTH-1:0] ram_write_data_o,
    output logic             ram_write_enable_o,
    input  logic [WIDTH-1:0] ram_read_data_i
);

    localparam int WC_W = $clog2(MAX_WAIT + 1);
    localparam int BC_W = $clog2(BURST_MAX + 1);
    localparam logic [WC_W-1:0] WAIT_SAT  = WC_W'(MAX_WAIT);
    localparam logic [BC_W-1:0] BEAT_LAST = BC_W'(BURST_MAX - 1);

    arb_state_e      state, state_nxt;
    arb_owner_e      owner;
    logic [WC_W-1:0] wait_cnt, wait_cnt_nxt;
    logic [BC_W-1:0] beat_cnt, beat_cnt_nxt;
    logic            ld_gnt;
    logic            rd_capture;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_PIPE;
            wait_cnt    <= '0;
            beat_cnt    <= '0;
            ld_rdata_o  <= '0;
            ld_rvalid_o <= 1'b0;
        end else begin
            state       <= state_nxt;
            wait_cnt    <= wait_cnt_nxt;
            beat_cnt    <= beat_cnt_nxt;
            ld_rvalid_o <= rd_capture;
            if (rd_capture) begin
                ld_rdata_o <= ram_read_data_i;
            end
        end
    end

    always_comb begin
        owner        = OWN_PIPE;
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        beat_cnt_nxt = beat_cnt;

        // An idle memory stage or an exhausted starvation window lets the loader in.
        if (state == S_LOAD) begin
            owner = OWN_LOAD;
        end else if (ld_req_i && (!pipe_req_i || wait_cnt == WAIT_SAT)) begin
            owner = OWN_LOAD;
        end

        ld_gnt     = ld_req_i && (owner == OWN_LOAD);
        rd_capture = ld_gnt && !ld_we_i;

        if (ld_gnt) begin
            if (ld_last_i || beat_cnt == BEAT_LAST) begin
                state_nxt    = S_PIPE;
                beat_cnt_nxt = '0;
            end else begin
                state_nxt    = S_LOAD;
                beat_cnt_nxt = beat_cnt + BC_W'(1);
            end
        end else if (state == S_LOAD) begin
            // Loader dropped its request mid-burst: hand the port back.
            state_nxt    = S_PIPE;
            beat_cnt_nxt = '0;
        end

        if (ld_gnt || !ld_req_i) begin
            wait_cnt_nxt = '0;
        end else if (owner == OWN_PIPE && wait_cnt != WAIT_SAT) begin
            wait_cnt_nxt = wait_cnt + WC_W'(1);
        end
    end

    always_comb begin
        pipe_rdata_o = ram_read_data_i;
        if (owner == OWN_LOAD) begin
            ram_adr_o          = ld_addr_i;
            ram_write_data_o   = ld_wdata_i;
            ram_write_enable_o = rst_n && ld_req_i && ld_we_i;
        end else begin
            ram_adr_o          = pipe_addr_i;
            ram_write_data_o   = pipe_wdata_i;
            ram_write_enable_o = rst_n && pipe_req_i && pipe_we_i;
        end
        pipe_stall_o = rst_n && pipe_req_i && (owner == OWN_LOAD);
        ld_gnt_o     = rst_n && ld_gnt;
    end

endmodule
